// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared states, CRC-32 constants and framing bytes for the receive framer
package eth_rx_pkg;
   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_t;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam int          DEF_MIN_LEN   = 64;
   localparam int          DEF_MAX_LEN   = 1518;
endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: one-byte update of the reflected Ethernet CRC-32
module eth_crc32_d8
   import eth_rx_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);
   logic [31:0] c;
   always_comb begin
      c = crc_in ^ {24'h0, data};
      for (int i = 0; i < 8; i++)
         c = c[0] ? (c >> 1) ^ CRC_POLY : c >> 1;
   end
   assign crc_out = c;
endmodule

// File: rtl/eth_rx_framer.sv
// eth_rx_framer: strips preamble/SFD/FCS from received bytes, checks CRC-32 and frame length
module eth_rx_framer
   import eth_rx_pkg::*;
#(
   parameter int MIN_LEN = DEF_MIN_LEN,
   parameter int MAX_LEN = DEF_MAX_LEN
) (
   input  logic        clk125MHz,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_en,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_sof,
   output logic        out_eof,
   output logic        frame_good,
   output logic        frame_bad,
   output logic [10:0] frame_len,
   output logic [15:0] crc_err_cnt
);
   localparam logic [10:0] MIN_L = 11'(MIN_LEN);
   localparam logic [10:0] MAX_L = 11'(MAX_LEN);
   localparam logic [10:0] ABORT_LEN = 11'(MAX_LEN - 4);
   rx_state_t   state;
   logic [31:0] crc, crc_next;
   logic [10:0] count;
   logic [7:0]  dly [5];
   logic        len_ok, crc_ok;
   eth_crc32_d8 u_crc (.crc_in(crc), .data(rx_data), .crc_out(crc_next));
   assign len_ok = count >= MIN_L && count <= MAX_L;
   assign crc_ok = crc == CRC_RESIDUE;
   // dly[4] is the oldest held byte; it is known not to be FCS once a fifth newer byte exists
   always_ff @(posedge clk125MHz or posedge rst)
      if (rst) begin
         state       <= IDLE;
         crc         <= CRC_INIT;
         count       <= '0;
         dly         <= '{default: '0};
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_sof     <= 1'b0;
         out_eof     <= 1'b0;
         frame_good  <= 1'b0;
         frame_bad   <= 1'b0;
         frame_len   <= '0;
         crc_err_cnt <= '0;
      end else begin
         out_valid  <= 1'b0;
         out_sof    <= 1'b0;
         out_eof    <= 1'b0;
         frame_good <= 1'b0;
         frame_bad  <= 1'b0;
         case (state)
            IDLE: if (rx_en) state <= rx_data == PREAMBLE_BYTE ? PREAMBLE : DROP;
            PREAMBLE: begin
               crc   <= CRC_INIT;
               count <= '0;
               if (!rx_en) state <= IDLE;
               else if (rx_data == SFD_BYTE) state <= DATA;
               else if (rx_data != PREAMBLE_BYTE) state <= DROP;
            end
            DATA:
               if (!rx_en) begin
                  state      <= IDLE;
                  out_data   <= dly[4];
                  out_valid  <= count > 11'd4;
                  out_sof    <= count == 11'd5;
                  out_eof    <= count > 11'd4;
                  frame_good <= crc_ok && len_ok;
                  frame_bad  <= !(crc_ok && len_ok);
                  frame_len  <= count > 11'd4 ? count - 11'd4 : '0;
                  if (len_ok && !crc_ok && crc_err_cnt != '1) crc_err_cnt <= crc_err_cnt + 16'd1;
               end else begin
                  crc       <= crc_next;
                  count     <= count + 11'(count != '1);
                  dly       <= '{rx_data, dly[0], dly[1], dly[2], dly[3]};
                  out_data  <= dly[4];
                  out_valid <= count >= 11'd5;
                  out_sof   <= count == 11'd5;
                  if (count == MAX_L) begin
                     state     <= DROP;
                     out_eof   <= 1'b1;
                     frame_bad <= 1'b1;
                     frame_len <= ABORT_LEN;
                  end
               end
            DROP: if (!rx_en) state <= IDLE;
         endcase
      end
endmodule

// File: doc/eth_rx_framer.md
ETH_RX_FRAMER -- requirements
Module: eth_rx_framer

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64: minimum legal frame bytes, destination address through FCS inclusive.
REQ-002 SHALL have parameter MAX_LEN, default 1518: maximum legal frame bytes, destination address through FCS inclusive.
REQ-003 SHALL have port clk125MHz  in  1  sole clock: one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port rx_data  in  8  byte from receive CDC FIFO.
REQ-006 SHALL have port rx_en  in  1  byte valid / frame in progress.
REQ-007 SHALL have port out_data  out  8  payload byte, preamble/SFD/FCS stripped.
REQ-008 SHALL have port out_valid  out  1  out_data valid.
REQ-009 SHALL have port out_sof  out  1  first payload byte, qualified by out_valid.
REQ-010 SHALL have port out_eof  out  1  last payload byte, qualified by out_valid.
REQ-011 SHALL have port frame_good  out  1  one-cycle pulse: frame accepted.
REQ-012 SHALL have port frame_bad  out  1  one-cycle pulse: frame rejected.
REQ-013 SHALL have port frame_len  out  11  payload byte count (excludes FCS); valid with frame_good/frame_bad.
REQ-014 SHALL have port crc_err_cnt  out  16  saturating count of CRC failures.

Function
REQ-015 SHALL implement states IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: rx_en=1 with 0x55 -> PREAMBLE; rx_en=1 with any other byte -> DROP.
REQ-017 PREAMBLE: 0x55 stays; 0xD5 -> DATA; any other byte -> DROP; rx_en=0 -> IDLE; no output and no pulse on any PREAMBLE exit.
REQ-018 DROP: ignores bytes; rx_en=0 -> IDLE.
REQ-019 DATA: every byte with rx_en=1 SHALL update CRC-32 (reflected, poly 0xEDB88320, init 0xFFFFFFFF) and increment an 11-bit count saturating at 2047.
REQ-020 DATA byte j SHALL be emitted on out_data in the cycle after byte j+5 arrives, or in the cycle after rx_en falls if byte j is the last non-FCS byte; the last four DATA bytes are never emitted.
REQ-021 out_sof SHALL accompany byte 1; out_eof SHALL accompany the final emitted byte, i.e. the cycle after rx_en falls in DATA.
REQ-022 At the rx_en fall in DATA: frame_good SHALL pulse iff CRC register equals residue 0xDEBB20E3 and MIN_LEN <= count <= MAX_LEN; otherwise frame_bad SHALL pulse; in both cases frame_len = count-4, same cycle as out_eof; state -> IDLE.
REQ-023 Frame with <=4 DATA bytes: SHALL emit no out_valid; frame_bad pulses, frame_len = 0.
REQ-024 When count reaches MAX_LEN+1: SHALL emit the held byte with out_eof=1, pulse frame_bad with frame_len = MAX_LEN-4 on the next cycle, and enter DROP; no further output until IDLE.
REQ-025 crc_err_cnt SHALL increment only on frame_bad caused by CRC mismatch, saturating at 0xFFFF.
REQ-026 All outputs SHALL be registered; out_valid/out_sof/out_eof/frame_good/frame_bad SHALL be 0 when not asserted.
REQ-027 A new 0x55 arriving in the cycle after a frame end SHALL be accepted into PREAMBLE while the end-of-frame outputs are driven.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, CRC to 0xFFFFFFFF, count/delay line to 0, and every output (including crc_err_cnt) to 0.
REQ-029 Reset mid-frame SHALL discard the frame: no out_eof, frame_good or frame_bad afterwards.

Structure
REQ-030 Shared package eth_rx_pkg SHALL hold the state enum, CRC polynomial, init and residue constants, preamble/SFD byte constants, and default MIN_LEN/MAX_LEN.
REQ-031 CRC byte update SHALL be a combinational sub-module eth_crc32_d8 (crc_in[31:0], data[7:0] -> crc_out[31:0]).

Verification
REQ-032 7x0x55, 0xD5, 60 payload + correct FCS -> 60 out bytes, out_sof byte 1, out_eof byte 60, frame_good, frame_len=60.
REQ-033 Same frame with one payload bit flipped -> 60 bytes emitted, frame_bad, crc_err_cnt=1.
REQ-034 Valid-CRC frame of 63 bytes -> frame_bad, frame_len=59, crc_err_cnt unchanged.
REQ-035 1600-byte frame -> out_eof and frame_bad at byte 1519 with frame_len=1514; no output afterwards; next good frame -> frame_good.
REQ-036 Preamble 0x55,0x54 -> DROP, no out_valid, no pulse; 3-byte DATA frame -> frame_bad only.
REQ-037 rst pulsed at payload byte 30 -> all outputs 0 immediately, no end pulse; following good 64-byte frame -> frame_good.
